// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and widths for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic RstEnable    = 1'b0;
  localparam logic RstDisable   = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam int RegAddrBus = 5;
  localparam int DataBus    = 32;
  localparam int WbReqNum   = 3;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the writeback requesters / issue stage and the arbiter.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = WbReqNum,
  parameter int AW   = RegAddrBus,
  parameter int DW   = DataBus
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_data;
  logic                    wreg;
  logic [AW-1:0]           waddr;
  logic [DW-1:0]           wdata;
  logic                    sb_set;
  logic [AW-1:0]           sb_set_addr;
  logic [AW-1:0]           chk_addr1;
  logic [AW-1:0]           chk_addr2;
  logic [AW-1:0]           chk_addr3;
  logic                    chk_busy1;
  logic                    chk_busy2;
  logic                    chk_busy3;
  logic                    flush;
  logic                    sb_err;

  modport master (
    output req_valid, req_addr, req_data, sb_set, sb_set_addr,
           chk_addr1, chk_addr2, chk_addr3, flush,
    input  req_ready, wreg, waddr, wdata, chk_busy1, chk_busy2, chk_busy3, sb_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, sb_set, sb_set_addr,
           chk_addr1, chk_addr2, chk_addr3, flush,
    output req_ready, wreg, waddr, wdata, chk_busy1, chk_busy2, chk_busy3, sb_err
  );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin priority search: first valid request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o
);
  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (en_i && !found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: round-robin share of the register-file write port plus a
// pending-write scoreboard used by issue to stall on in-flight destinations.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = WbReqNum,
  parameter int AW   = RegAddrBus,
  parameter int DW   = DataBus
) (
  input  logic              clk,
  input  logic              resetn,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int NR = 1 << AW;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NR-1:0]   pending_q, pending_d;
  logic            sb_err_q, sb_err_d;
  logic            wreg_q, wreg_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic            xfer;
  logic [AW-1:0]   gaddr;
  logic [DW-1:0]   gdata;

  // Flush masks the search so no requester sees ready during it.
  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (~bus.flush),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  // A grant only ever goes to a valid requester, so grant == transfer.
  assign bus.req_ready = gnt;
  assign xfer          = |gnt;
  assign gaddr         = bus.req_addr[gidx];
  assign gdata         = bus.req_data[gidx];

  // Next-state for pointer, write port and scoreboard.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    pending_d = pending_q;
    sb_err_d  = sb_err_q;
    wreg_d    = WriteDisable;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    if (xfer) begin
      rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
      wreg_d   = (gaddr != '0) ? WriteEnable : WriteDisable;
      waddr_d  = gaddr;
      wdata_d  = gdata;
    end
    if (bus.flush) begin
      pending_d = '0;
    end else begin
      // Clear first so a same-edge set to the same register wins.
      if (xfer && gaddr != '0) pending_d[gaddr] = 1'b0;
      if (bus.sb_set && bus.sb_set_addr != '0) begin
        if (pending_q[bus.sb_set_addr]) sb_err_d = 1'b1;
        pending_d[bus.sb_set_addr] = 1'b1;
      end
    end
  end

  // State registers; reset wipes everything, including unissued writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (resetn == RstEnable) begin
      rr_ptr_q  <= '0;
      pending_q <= '0;
      sb_err_q  <= 1'b0;
      wreg_q    <= WriteDisable;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
      wreg_q    <= wreg_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.wreg   = wreg_q;
  assign bus.waddr  = waddr_q;
  assign bus.wdata  = wdata_q;
  assign bus.sb_err = sb_err_q;

  // Register 0 is never tracked; busy drops as soon as the write is accepted.
  assign bus.chk_busy1 = (bus.chk_addr1 != '0) & pending_q[bus.chk_addr1];
  assign bus.chk_busy2 = (bus.chk_addr2 != '0) & pending_q[bus.chk_addr2];
  assign bus.chk_busy3 = (bus.chk_addr3 != '0) & pending_q[bus.chk_addr3];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus random check of regfile_wb_arbiter against a simple model.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk;
  logic resetn;
  int   checks;
  int   errs;

  // Reference model state
  int          m_ptr;
  bit [31:0]   m_pend;
  bit          m_err;
  bit          m_wreg;
  bit [AW-1:0] m_waddr;
  bit [DW-1:0] m_wdata;

  regfile_wb_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();

  regfile_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.sb_set      = 1'b0;
    bus.sb_set_addr = '0;
    bus.chk_addr1   = '0;
    bus.chk_addr2   = '0;
    bus.chk_addr3   = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pend = '0; m_err = 0;
    m_wreg = 0; m_waddr = '0; m_wdata = '0;
  endtask

  // Called shortly after a rising edge; leaves time at the next edge + 1.
  task automatic reset_dut();
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_wreg", bus.wreg, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_err", bus.sb_err, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle_inputs();
  endtask

  function automatic bit busy_of(input logic [AW-1:0] a);
    return (a != 0) && m_pend[a];
  endfunction

  // One cycle: check combinational outputs against the model, clock, then
  // advance the model and check the registered outputs.
  task automatic step();
    int g;
    int j;
    bit [31:0] old;
    logic [AW-1:0] a;
    #1;
    g = -1;
    if (!bus.flush)
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && bus.req_valid[j]) g = j;
      end
    chk("ready", bus.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("busy1", bus.chk_busy1, busy_of(bus.chk_addr1));
    chk("busy2", bus.chk_busy2, busy_of(bus.chk_addr2));
    chk("busy3", bus.chk_busy3, busy_of(bus.chk_addr3));
    old = m_pend;
    if (g >= 0) begin
      a = bus.req_addr[g];
      m_wreg  = (a != 0);
      m_waddr = a;
      m_wdata = bus.req_data[g];
      m_ptr   = (g + 1) % N;
    end else begin
      m_wreg = 0;
    end
    if (bus.flush) m_pend = '0;
    else begin
      if (g >= 0 && bus.req_addr[g] != 0) m_pend[bus.req_addr[g]] = 0;
      if (bus.sb_set && bus.sb_set_addr != 0) begin
        if (old[bus.sb_set_addr]) m_err = 1;
        m_pend[bus.sb_set_addr] = 1;
      end
    end
    @(posedge clk); #1;
    chk("wreg", bus.wreg, m_wreg);
    chk("waddr", bus.waddr, m_waddr);
    chk("wdata", bus.wdata, m_wdata);
    chk("sb_err", bus.sb_err, m_err);
  endtask

  initial begin
    checks = 0;
    errs   = 0;
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    reset_dut();

    // Single requester
    bus.req_valid = 3'b001; bus.req_addr[0] = 5; bus.req_data[0] = 32'h1234_5678;
    #1 chk("single_ready", bus.req_ready, 3'b001);
    step();
    chk("single_wreg", bus.wreg, 1);
    chk("single_waddr", bus.waddr, 5);
    chk("single_wdata", bus.wdata, 32'h1234_5678);
    bus.req_valid = '0;
    step();
    chk("single_idle", bus.wreg, 0);
    chk("single_hold", bus.waddr, 5);

    // Round-robin from pointer 0
    reset_dut();
    bus.req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i] = AW'(i + 1);
      bus.req_data[i] = 32'hA000_0000 + i;
    end
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_grant", bus.req_ready, 3'b001 << (c % 3));
      step();
      chk("rr_wreg", bus.wreg, 1);
      chk("rr_waddr", bus.waddr, (c % 3) + 1);
    end
    bus.req_valid = '0;

    // Scoreboard set then clear by writeback
    bus.sb_set = 1; bus.sb_set_addr = 7;
    step();
    bus.sb_set = 0; bus.chk_addr1 = 7;
    #1 chk("sb_busy7", bus.chk_busy1, 1);
    bus.req_valid = 3'b010; bus.req_addr[1] = 7; bus.req_data[1] = 32'hDEAD_0007;
    #1 chk("sb_ready1", bus.req_ready, 3'b010);
    step();
    bus.req_valid = '0;
    #1 chk("sb_busy7_clr", bus.chk_busy1, 0);
    chk("sb_wr7", {bus.wreg, bus.waddr}, {1'b1, 5'd7});

    // Same-edge set and clear: set wins, no error; second set errors
    bus.req_valid = 3'b001; bus.req_addr[0] = 9; bus.req_data[0] = 32'h9;
    bus.sb_set = 1; bus.sb_set_addr = 9; bus.chk_addr1 = 9;
    step();
    bus.req_valid = '0;
    bus.sb_set = 0;
    #1 chk("coll_busy9", bus.chk_busy1, 1);
    chk("coll_noerr", bus.sb_err, 0);
    bus.sb_set = 1;
    step();
    bus.sb_set = 0;
    chk("coll_err", bus.sb_err, 1);

    // Address 0 is accepted but never written or tracked
    bus.req_valid = 3'b100; bus.req_addr[2] = 0; bus.req_data[2] = 32'hFFFF;
    #1 chk("a0_ready", bus.req_ready, 3'b100);
    step();
    bus.req_valid = '0;
    chk("a0_wreg", bus.wreg, 0);
    bus.sb_set = 1; bus.sb_set_addr = 0; bus.chk_addr2 = 0;
    step();
    bus.sb_set = 0;
    #1 chk("a0_busy", bus.chk_busy2, 0);

    // Flush clears pending and blocks grants
    reset_dut();
    bus.sb_set = 1; bus.sb_set_addr = 3; step();
    bus.sb_set_addr = 4; step();
    bus.sb_set = 0;
    bus.chk_addr1 = 3; bus.chk_addr2 = 4;
    #1 chk("fl_pre", {bus.chk_busy1, bus.chk_busy2}, 2'b11);
    bus.flush = 1; bus.req_valid = 3'b011; bus.req_addr[0] = 3; bus.req_addr[1] = 4;
    #1 chk("fl_ready", bus.req_ready, 0);
    step();
    bus.flush = 0; bus.req_valid = '0;
    #1 chk("fl_busy", {bus.chk_busy1, bus.chk_busy2}, 2'b00);
    chk("fl_wreg", bus.wreg, 0);

    // Random traffic against the model
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) reset_dut();
      bus.req_valid = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        bus.req_addr[i] = AW'($urandom_range(0, 15));
        bus.req_data[i] = $urandom;
      end
      bus.sb_set      = ($urandom_range(0, 9) < 3);
      bus.sb_set_addr = AW'($urandom_range(0, 15));
      bus.chk_addr1   = AW'($urandom_range(0, 15));
      bus.chk_addr2   = AW'($urandom_range(0, 15));
      bus.chk_addr3   = AW'($urandom_range(0, 15));
      bus.flush       = ($urandom_range(0, 9) == 0);
      step();
    end

    // Asynchronous reset in the middle of a burst
    idle_inputs();
    bus.req_valid = 3'b111;
    for (int i = 0; i < N; i++) bus.req_addr[i] = AW'(i + 10);
    step();
    step();
    #3 resetn = 1'b0;
    #1;
    chk("mid_rst_wreg", bus.wreg, 0);
    chk("mid_rst_ptr", bus.req_ready, 3'b001);
    chk("mid_rst_err", bus.sb_err, 0);
    #1 resetn = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("post_rst_wreg", bus.wreg, 1);
    chk("post_rst_waddr", bus.waddr, 10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (wreg/waddr/wdata) between several writeback requesters, e.g. ALU, load unit and mul/div unit, in the multicycle CPU.
- Arbitrates round-robin with a valid/ready handshake and drives the write port from registers.
- Keeps a pending-write scoreboard so the issue/decode stage can stall on source or destination registers whose writes are still outstanding.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  requester i is granted this cycle; combinational from req_valid, flush and the pointer.
- req_addr  in  NREQ*AW  destination of requester i, in slice i.
- req_data  in  NREQ*DW  write data of requester i, in slice i.
- wreg  out  1  register-file write enable, registered.
- waddr  out  AW  register-file write address, registered.
- wdata  out  DW  register-file write data, registered.
- sb_set  in  1  issue stage marks a destination pending.
- sb_set_addr  in  AW  destination being marked.
- chk_addr1  in  AW  source 1 to check.
- chk_addr2  in  AW  source 2 to check.
- chk_addr3  in  AW  destination to check.
- chk_busy1  out  1  chk_addr1 has an outstanding write; combinational.
- chk_busy2  out  1  chk_addr2 has an outstanding write; combinational.
- chk_busy3  out  1  chk_addr3 has an outstanding write; combinational.
- flush  in  1  synchronous pipeline flush.
- sb_err  out  1  sticky protocol-error flag, registered.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (resetn).
- Reset values: wreg=0, waddr=0, wdata=0, rr_ptr=0, pending[31:0]=0, sb_err=0.

Arbitration:
- At most one grant per cycle. Search req_valid starting at index rr_ptr, wrapping modulo NREQ. The first valid index g is granted and req_ready[g]=1; all other req_ready bits are 0.
- No valid request, or flush=1: no grant, and req_ready is all 0.
- A transfer happens when req_valid[g] && req_ready[g]. At that rising edge: rr_ptr <= (g+1) mod NREQ. If no transfer, rr_ptr holds.
- Requesters hold valid, addr and data stable until ready. Dropping valid without ready is allowed: nothing is accepted.

Write port:
- Latency is 1 cycle. A transfer at edge t gives wreg=1, waddr=req_addr[g], wdata=req_data[g] during cycle t+1.
- If req_addr[g]==0, the transfer is still accepted (ready=1), but wreg=0 in t+1. Register 0 is never written.
- No transfer at edge t: wreg=0 in t+1; waddr and wdata hold their previous values.
- The register file always accepts, so there is no backpressure on the output.
- A write already registered before flush still issues. Flush only suppresses new grants.

Scoreboard:
- At an edge with a transfer to address a, where a!=0: pending[a] <= 0.
- At an edge with sb_set && sb_set_addr!=0: pending[sb_set_addr] <= 1.
- Set and clear to the same address at the same edge: set wins.
- sb_set to an address already pending: bit stays 1 and sb_err <= 1. sb_err stays 1 until reset.
- chk_busyN = pending[chk_addrN], and is always 0 for address 0.
- The cycle after acceptance, the register file's same-cycle write bypass supplies the data, so the busy bit is already 0 in that cycle.
- flush=1 at an edge clears all pending bits; a same-edge sb_set is ignored. Transfers are blocked during flush.

Reset mid-operation: all state and outputs return to reset values immediately, asynchronously. Accepted but unissued writes are lost.

Decomposition:
- Shared define file: reuse WriteEnable, WriteDisable, RstEnable, RstDisable and ZeroWord; add RegAddrBus width (5) and WbReqNum (3).
- Sub-module rr_arbiter (NREQ): inputs req vector, ptr and en; outputs one-hot grant and encoded index. Pointer update stays in the parent.

Test Plan:
- Single requester: after reset, req0 valid with addr=5, data=0x1234_5678 → ready0=1 in the same cycle; next cycle wreg=1, waddr=5, wdata=0x12345678; the following cycle wreg=0.
- Round-robin: all three valid continuously, distinct addrs 1/2/3 → grants 0,1,2,0,1,2 on consecutive cycles; wreg=1 every cycle from the second.
- Scoreboard: sb_set addr 7 → chk_busy1(chk_addr1=7)=1 the next cycle; req1 writes addr 7 → busy=0 the cycle after acceptance, while wreg=1/waddr=7.
- Same-edge collision: transfer to addr 9 while sb_set addr 9 → pending[9]=1 afterwards and sb_err=0; a second sb_set 9 → sb_err=1.
- Address 0: req2 valid addr=0 → ready2=1, next cycle wreg=0; sb_set addr 0 → chk_busy for addr 0 stays 0.
- Flush and reset: flush with two valids and pending bits 3 and 4 → no ready, pending all 0. Assert resetn=0 mid-burst → wreg=0 and rr_ptr=0 immediately, with no clock edge needed.
